// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// state encoding and default sizing.
package seq_multiplier_pkg;

  // Default operand/product width and iteration counter width (must hold MULT_WIDTH).
  localparam int unsigned MULT_WIDTH = 16;
  localparam int unsigned MULT_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : seq_multiplier_pkg

// File: rtl/seq_multiplier_datapath.sv
// Shift-add datapath: multiplicand/multiplier shift registers and accumulator.
// Ports:
//   clock, reset (sync, active-low), clock_valid (edge qualifier)
//   load       - capture a/b and clear the accumulator
//   step       - perform one shift-add iteration
//   a, b       - operands captured on load
//   acc_next_c - accumulator value after the current iteration's add (combinational)
module seq_multiplier_datapath #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clock_valid,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] acc_next_c
);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;

  // Add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_next_c = acc;
    if (mplier[0]) begin
      acc_next_c = acc + mcand;
    end
  end

  // Operand shift registers and accumulator; invalid edges are ignored entirely.
  always_ff @(posedge clock) begin
    if (clock_valid) begin
      if (!reset) begin
        mcand  <= '0;
        mplier <= '0;
        acc    <= '0;
      end else if (load) begin
        mcand  <= {{WIDTH{1'b0}}, a};
        mplier <= b;
        acc    <= '0;
      end else if (step) begin
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        acc    <= acc_next_c;
      end
    end
  end

endmodule : seq_multiplier_datapath

// File: rtl/seq_multiplier.sv
// Multicycle unsigned WIDTHxWIDTH shift-add multiplier, one multiplier bit per
// valid clock, fixed latency of WIDTH valid edges from start to done.
// Ports:
//   clock, reset (sync, active-low), clock_valid (edge qualifier)
//   start    - request a multiply (sampled only while idle)
//   a, b     - multiplicand / multiplier
//   busy     - registered, high while not idle
//   done     - one-cycle completion strobe
//   product  - low WIDTH bits of a*b, held until the next completion
//   overflow - high WIDTH bits of a*b are nonzero
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH,
  parameter int unsigned CNT_W = MULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clock_valid,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             overflow
);

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   count;
  logic               load_c;
  logic               step_c;
  logic               last_c;
  logic [2*WIDTH-1:0] acc_next_c;

  seq_multiplier_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clock      (clock),
    .reset      (reset),
    .clock_valid(clock_valid),
    .load       (load_c),
    .step       (step_c),
    .a          (a),
    .b          (b),
    .acc_next_c (acc_next_c)
  );

  // Next-state and datapath control.
  always_comb begin
    next_state = state;
    load_c     = 1'b0;
    step_c     = 1'b0;
    last_c     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_c     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        step_c = 1'b1;
        // The iteration performed while count==WIDTH-1 is the final one.
        if (count == CNT_W'(WIDTH - 1)) begin
          last_c     = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs.
  always_ff @(posedge clock) begin
    if (clock_valid) begin
      if (!reset) begin
        state    <= IDLE;
        count    <= '0;
        busy     <= 1'b0;
        done     <= 1'b0;
        product  <= '0;
        overflow <= 1'b0;
      end else begin
        state <= next_state;
        busy  <= (next_state != IDLE);
        done  <= last_c;
        if (load_c) begin
          count <= '0;
        end else if (step_c) begin
          count <= count + CNT_W'(1);
        end
        if (last_c) begin
          product  <= acc_next_c[WIDTH-1:0];
          overflow <= |acc_next_c[2*WIDTH-1:WIDTH];
        end
      end
    end
  end

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// Directed testbench for seq_multiplier.
module tb_seq_multiplier;

  logic        clock;
  logic        reset;
  logic        clock_valid;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  seq_multiplier dut (
    .clock      (clock),
    .reset      (reset),
    .clock_valid(clock_valid),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Step until done is seen; n is the number of edges taken (bounded).
  task automatic wait_done(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!done && n < 40);
  endtask

  // Full multiply from idle: checks latency, result and the falling edge of done.
  task automatic run_mult(input string tag, input logic [15:0] av, input logic [15:0] bv,
                          input logic [15:0] exp_p, input logic exp_o);
    int n;
    a = av; b = bv; start = 1'b1;
    step();
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(n);
    check({tag, "_lat"}, 32'(n), 32'd16);
    check({tag, "_prod"}, 32'(product), 32'(exp_p));
    check({tag, "_ovf"}, 32'(overflow), 32'(exp_o));
    step();
    check({tag, "_done_fall"}, 32'(done), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int ndone;
    reset = 1'b0; clock_valid = 1'b1; start = 1'b0; a = '0; b = '0;
    step();
    step();
    reset = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_prod", 32'(product), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // 3x5 with per-edge done watch.
    a = 16'd3; b = 16'd5; start = 1'b1;
    step();
    start = 1'b0;
    check("m35_busy0", 32'(busy), 32'd1);
    for (int e = 1; e <= 15; e++) begin
      step();
      check("m35_no_early_done", 32'(done), 32'd0);
    end
    step();
    check("m35_done", 32'(done), 32'd1);
    check("m35_busy16", 32'(busy), 32'd1);
    check("m35_prod", 32'(product), 32'h000F);
    check("m35_ovf", 32'(overflow), 32'd0);
    step();
    check("m35_done_fall", 32'(done), 32'd0);
    check("m35_idle", 32'(busy), 32'd0);
    check("m35_prod_hold", 32'(product), 32'h000F);

    // Boundary vectors.
    run_mult("ffff", 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1);
    run_mult("0100", 16'h0100, 16'h0100, 16'h0000, 1'b1);
    run_mult("00ff", 16'h00FF, 16'h0101, 16'hFFFF, 1'b0);

    // Start while busy is ignored; held start is accepted only after done falls.
    a = 16'd7; b = 16'd9; start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    for (int e = 1; e <= 17; e++) begin
      if (e == 5) begin
        start = 1'b1; a = 16'd2; b = 16'd2;
      end
      step();
      if (done) begin
        ndone++;
        check("m79_prod", 32'(product), 32'h003F);
        check("m79_edge", 32'(e), 32'd16);
      end
    end
    check("m79_single_done", 32'(ndone), 32'd1);
    check("m79_idle_after", 32'(busy), 32'd0);
    step();
    start = 1'b0;
    check("m22_accept", 32'(busy), 32'd1);
    check("m22_prod_stable", 32'(product), 32'h003F);
    wait_done(n);
    check("m22_lat", 32'(n), 32'd16);
    check("m22_prod", 32'(product), 32'h0004);
    step();

    // clock_valid gap of 5 cycles starting at edge 8 stretches latency by 5.
    a = 16'd3; b = 16'd5; start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e <= 7; e++) step();
    clock_valid = 1'b0;
    for (int g = 0; g < 5; g++) begin
      step();
      check("gap_busy", 32'(busy), 32'd1);
      check("gap_done", 32'(done), 32'd0);
      check("gap_prod", 32'(product), 32'h0004);
    end
    clock_valid = 1'b1;
    wait_done(n);
    check("gap_lat", 32'(n + 12), 32'd21);
    check("gap_prod_final", 32'(product), 32'h000F);
    step();

    // Reset mid-run discards the partial result.
    run_mult("pre_rst", 16'd3, 16'd5, 16'h000F, 1'b0);
    a = 16'd4; b = 16'd4; start = 1'b1;
    step();
    start = 1'b0;
    for (int e = 1; e <= 9; e++) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_prod", 32'(product), 32'd0);
    check("mrst_ovf", 32'(overflow), 32'd0);
    ndone = 0;
    for (int e = 0; e < 20; e++) begin
      step();
      if (done) ndone++;
    end
    check("mrst_no_done", 32'(ndone), 32'd0);
    run_mult("post_rst", 16'd4, 16'd4, 16'h0010, 1'b0);

    // Reset during invalid cycles waits for a valid edge.
    a = 16'd3; b = 16'd5; start = 1'b1;
    step();
    start = 1'b0;
    step();
    clock_valid = 1'b0;
    reset = 1'b0;
    for (int g = 0; g < 3; g++) step();
    check("cvrst_busy_hold", 32'(busy), 32'd1);
    check("cvrst_prod_hold", 32'(product), 32'h0010);
    clock_valid = 1'b1;
    step();
    reset = 1'b1;
    check("cvrst_busy", 32'(busy), 32'd0);
    check("cvrst_prod", 32'(product), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seq_multiplier

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
- Multicycle unsigned 16x16 shift-add multiplier. Sits directly upstream of a 16-bit datapath register.
- Takes two operands on a start pulse and iterates one multiplier bit per valid clock.
- Presents the low half of the product with a one-cycle done strobe. The strobe drives the downstream register's write input directly.
- Same clock_valid gating discipline as the rest of the datapath.

Parameters:
- WIDTH, 16, operand and product-output width. Internal accumulator is 2*WIDTH.
- CNT_W, 5, iteration counter width. Must hold the value WIDTH.

Ports:
- clock  input  1  system clock; all state changes on posedge.
- reset  input  1  synchronous, active-low; state cleared on a valid posedge when reset==0.
- clock_valid  input  1  when 0, the posedge is ignored entirely: state and all outputs hold.
- start  input  1  request a multiply; sampled only when busy==0.
- a  input  WIDTH  multiplicand; captured on accepted start.
- b  input  WIDTH  multiplier; captured on accepted start.
- busy  output  1  high from the edge after an accepted start until done falls.
- done  output  1  one-cycle pulse; product/overflow are valid and newly updated.
- product  output  WIDTH  low WIDTH bits of a*b; holds until the next completion.
- overflow  output  1  1 when the high WIDTH bits of the full product are nonzero.

Behaviour:
- Edge priority, every posedge, in order:
  - clock_valid==0 → nothing changes.
  - else reset==0 → reset.
  - else normal operation.
- Reset values: state=IDLE, busy=0, done=0, product=0, overflow=0, counter=0, accumulator=0.
- State IDLE:
  - start==1 at edge k → load mcand={WIDTH zeros, a}, mplier=b, acc=0, count=0; go to RUN.
  - start==0 → stay in IDLE.
- State RUN, each valid edge:
  - If mplier[0], acc=acc+mcand (2*WIDTH-bit add, no carry out possible).
  - mcand<<=1, mplier>>=1, count++.
  - On the edge where count reaches WIDTH-1 (16th iteration):
    - product←low WIDTH of the final acc.
    - overflow←|(high WIDTH of the final acc).
    - done←1; go to DONE.
- State DONE: lasts one valid cycle; done←0; go to IDLE.
- busy: registered, equals (state != IDLE).
- Latency: start sampled at valid edge k → done high after valid edge k+WIDTH (k+16) → done low after k+WIDTH+1.
  - Fixed latency: no early termination for zero or small operands.
- Only valid edges count. Invalid (clock_valid==0) cycles stretch latency 1:1.
- start while busy==1 (RUN or DONE) is ignored; it is not queued.
- Earliest next accepted start is at the valid edge after done falls.
- a and b are don't-care except at the accepting edge.
- product and overflow change only on the completing edge or on reset. They are stable at all other times, including during a new run.
- Reset mid-RUN or in DONE: immediate return to IDLE with all reset values; no done pulse; the partial result is discarded.
- reset==0 with clock_valid==0: no effect until a valid edge.
- done is never high for more than one valid cycle. done==1 implies busy==1.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - the default WIDTH=16.
  - CNT_W.
- The product output is held internally, not by the downstream register.
- Optional sub-module mult_datapath:
  - contains the accumulator, shift registers and adder, with load/step controls.
  - the FSM and counter stay in seq_multiplier.

Test Plan:
- Reset with clock_valid=1, then a=3, b=5, start pulse at edge 0 → busy=1 from edge 1; done=1 only after edge 16; product=0x000F, overflow=0; busy=0 after edge 17.
- a=0xFFFF, b=0xFFFF → product=0x0001, overflow=1. a=0x0100, b=0x0100 → product=0x0000, overflow=1. a=0x00FF, b=0x0101 → product=0xFFFF, overflow=0.
- During a 7x9 run, pulse start at edge 5 with a=2, b=2, and hold start high through the DONE cycle → single done; product=0x003F. The next multiply begins only on a start sampled after done falls.
- 3x5 run with clock_valid=0 for 5 cycles starting at edge 8 → all outputs frozen during the gap; done asserted 5 cycles later than nominal; product=0x000F.
- Complete 3x5 (product=0x000F), start 4x4, assert reset=0 at RUN edge 10 → after that edge busy=0, done=0, product=0, overflow=0. No done follows; a fresh 4x4 then yields 0x0010 with nominal latency.
- Reset asserted while clock_valid=0 → no state change; takes effect on the first edge with clock_valid=1.
